// File: rtl/store_monitor.sv
// Watches a core's store bus and resolves a self-test to PASS, FAIL or timeout.
// All outputs come straight from flops; terminal states freeze every counter.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOW_ADDR     = 32'd80,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [15:0] store_count,
  output logic [31:0] cycle_count,
  output logic [31:0] err_addr,
  output logic [31:0] err_data
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ADDR    = 2'b01;
  localparam logic [1:0] FC_DATA    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  logic [1:0]  state_q, state_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  fail_code_q, fail_code_d;
  logic [15:0] store_count_q, store_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] err_data_q, err_data_d;
  logic        terminating;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through this block infers a latch.
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    store_count_d = store_count_q;
    cycle_count_d = cycle_count_q;
    err_addr_d    = err_addr_q;
    err_data_d    = err_data_q;
    terminating   = 1'b0;

    if (state_q == ST_RUN) begin
      cycle_count_d = cycle_count_q + 32'd1;

      if (memwrite) begin
        if (store_count_q != 16'hFFFF) begin
          store_count_d = store_count_q + 16'd1;
        end

        if (dataadr == PASS_ADDR) begin
          terminating = 1'b1;
          if (writedata == PASS_DATA) begin
            state_d = ST_PASS;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = FC_DATA;
            err_addr_d  = dataadr;
            err_data_d  = writedata;
          end
        end else if (dataadr != ALLOW_ADDR) begin
          terminating = 1'b1;
          state_d     = ST_FAIL;
          fail_code_d = FC_ADDR;
          err_addr_d  = dataadr;
          err_data_d  = writedata;
        end
      end

      // A store that resolves the test on the last allowed edge wins over the timeout.
      if (!terminating && (cycle_count_q == TIMEOUT_LAST)) begin
        state_d     = ST_FAIL;
        fail_code_d = FC_TIMEOUT;
        err_addr_d  = 32'd0;
        err_data_d  = 32'd0;
      end
    end

    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
    if (state_d != ST_FAIL) begin
      fail_code_d = FC_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= FC_NONE;
      store_count_q <= 16'd0;
      cycle_count_q <= 32'd0;
      err_addr_q    <= 32'd0;
      err_data_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_code_q   <= fail_code_d;
      store_count_q <= store_count_d;
      cycle_count_q <= cycle_count_d;
      err_addr_q    <= err_addr_d;
      err_data_q    <= err_data_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign store_count = store_count_q;
  assign cycle_count = cycle_count_q;
  assign err_addr    = err_addr_q;
  assign err_data    = err_data_q;

endmodule
